dmem_arbiter: RTL and testbench

Arbiter that shares the single DMEM port between the processor's memory stage and the FFT accelerator's data mover. It sits between the processor and the DMEM in the wrapper:
- Processor memory-stage traffic gets single-cycle priority.
- The accelerator gets burst ownership, bounded by a beat limit and protected from starvation by a wait counter.
- The processor is stalled, not dropped, whenever it loses arbitration.

---
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares one DMEM port: the CPU gets zero-latency grants, the accelerator gets bounded bursts with anti-starvation.
// Losers are stalled (CPU) or not granted (acc); acc read data is registered (+1 cycle). Stats: DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wren,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_data,
  output logic        cpu_stall,
  output logic [31:0] cpu_q,
  input  logic        acc_req,
  input  logic        acc_wren,
  input  logic [31:0] acc_addr,
  input  logic [31:0] acc_data,
  input  logic        acc_last,
  output logic        acc_gnt,
  output logic [31:0] acc_q,
  output logic        acc_q_valid,
  output logic [31:0] address_dmem,
  output logic [31:0] data,
  output logic        wren,
  input  logic [31:0] q_dmem,
  output logic [31:0] stat_cpu_stalls,
  output logic [31:0] stat_acc_beats
);

  typedef enum logic {OPEN = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [8:0] MAX_B      = 9'(MAX_BURST);
  localparam logic [7:0] STARVE_L   = 8'(STARVE_LIMIT);
  localparam bit         MULTI_BEAT = (MAX_BURST > 1);

  state_t      state_q, state_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [7:0]  starve_cnt_q, starve_cnt_d;
  logic [8:0]  beat_inc;
  logic        cpu_grant, acc_grant;
  logic [31:0] acc_q_q;
  logic        acc_q_valid_q;

  assign beat_inc = {1'b0, beat_cnt_q} + 9'd1;

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    cpu_grant    = 1'b0;
    acc_grant    = 1'b0;
    if (!reset) begin
      case (state_q)
        OPEN: begin
          if (cpu_req && !(acc_req && starve_cnt_q == STARVE_L)) begin
            cpu_grant = 1'b1;
          end else if (acc_req) begin
            acc_grant  = 1'b1;
            beat_cnt_d = 8'd1;
            if (!acc_last && MULTI_BEAT) state_d = LOCK;
          end
        end
        LOCK: begin
          // A dropped request in LOCK abandons the burst and reopens arbitration.
          if (acc_req) begin
            acc_grant  = 1'b1;
            beat_cnt_d = beat_inc[7:0];
            if (acc_last || beat_inc == MAX_B) state_d = OPEN;
          end else begin
            state_d = OPEN;
          end
        end
        default: state_d = OPEN;
      endcase
      if (acc_grant || !acc_req) begin
        starve_cnt_d = 8'd0;
      end else if (state_q == OPEN && starve_cnt_q != STARVE_L) begin
        starve_cnt_d = starve_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= OPEN;
      beat_cnt_q    <= 8'd0;
      starve_cnt_q  <= 8'd0;
      acc_q_q       <= 32'd0;
      acc_q_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      if (acc_grant && !acc_wren) begin
        acc_q_q       <= q_dmem;
        acc_q_valid_q <= 1'b1;
      end else begin
        acc_q_valid_q <= 1'b0;
      end
    end
  end

  assign cpu_stall    = cpu_req && !cpu_grant;
  assign cpu_q        = q_dmem;
  assign acc_gnt      = acc_grant;
  assign acc_q        = acc_q_q;
  assign acc_q_valid  = acc_q_valid_q;
  assign address_dmem = cpu_grant ? cpu_addr : (acc_grant ? acc_addr : 32'd0);
  assign data         = cpu_grant ? cpu_data : (acc_grant ? acc_data : 32'd0);
  assign wren         = (cpu_grant && cpu_wren) || (acc_grant && acc_wren);

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_cpu_stalls_q, stat_acc_beats_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_cpu_stalls_q <= 32'd0;
      stat_acc_beats_q  <= 32'd0;
    end else begin
      if (cpu_stall) stat_cpu_stalls_q <= stat_cpu_stalls_q + 32'd1;
      if (acc_grant) stat_acc_beats_q  <= stat_acc_beats_q + 32'd1;
    end
  end

  assign stat_cpu_stalls = stat_cpu_stalls_q;
  assign stat_acc_beats  = stat_acc_beats_q;
`else
  assign stat_cpu_stalls = 32'd0;
  assign stat_acc_beats  = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a cycle model.
module tb_dmem_arbiter;

  localparam int MAX_BURST    = 8;
  localparam int STARVE_LIMIT = 4;
`ifdef DMEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_wren = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_data = '0;
  logic        acc_req = 1'b0, acc_wren = 1'b0, acc_last = 1'b0;
  logic [31:0] acc_addr = '0, acc_data = '0;
  logic        cpu_stall, acc_gnt, acc_q_valid, wren;
  logic [31:0] cpu_q, acc_q, address_dmem, data, q_dmem, stat_cpu_stalls, stat_acc_beats;

  dmem_arbiter #(.MAX_BURST(MAX_BURST), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_stall(cpu_stall), .cpu_q(cpu_q),
    .acc_req(acc_req), .acc_wren(acc_wren), .acc_addr(acc_addr), .acc_data(acc_data),
    .acc_last(acc_last), .acc_gnt(acc_gnt), .acc_q(acc_q), .acc_q_valid(acc_q_valid),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem),
    .stat_cpu_stalls(stat_cpu_stalls), .stat_acc_beats(stat_acc_beats)
  );

  always #5 clock = ~clock;

  // Falling-edge style RAM: read is combinational, write lands at the rising edge.
  logic [31:0] mem [256];
  logic        mem_clr = 1'b1;
  assign q_dmem = mem[address_dmem[7:0]];
  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i) * 32'd3 + 32'd7;
    end else if (wren) begin
      mem[address_dmem[7:0]] <= data;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner-of-burst flag, beats taken so far, cycles the accelerator has been refused.
  bit          m_locked = 0;
  int          m_beats  = 0;
  int          m_denied = 0;
  logic [31:0] m_accq   = '0;
  bit          m_accqv  = 0;
  logic [31:0] m_stalls = '0, m_beatcnt = '0;

  logic        exp_cpu_g, exp_acc_g, exp_stall, exp_wren, exp_cpu_rd, exp_accqv;
  logic [31:0] exp_addr, exp_data, exp_cpu_q, exp_accq, exp_stalls, exp_beatcnt;
  logic        obs_acc_gnt, obs_stall, obs_wren, obs_accqv;
  logic [31:0] obs_addr, obs_data, obs_cpu_q, obs_accq, obs_stalls, obs_beatcnt;

  task automatic step();
    logic [31:0] rd_val;
    @(negedge clock);
    exp_cpu_g = 1'b0;
    exp_acc_g = 1'b0;
    if (!reset) begin
      if (m_locked) exp_acc_g = acc_req;
      else if (cpu_req && !(acc_req && m_denied >= STARVE_LIMIT)) exp_cpu_g = 1'b1;
      else exp_acc_g = acc_req;
    end
    exp_stall  = cpu_req && !exp_cpu_g;
    exp_wren   = exp_cpu_g ? cpu_wren : (exp_acc_g ? acc_wren : 1'b0);
    exp_addr   = exp_cpu_g ? cpu_addr : (exp_acc_g ? acc_addr : 32'd0);
    exp_data   = exp_cpu_g ? cpu_data : (exp_acc_g ? acc_data : 32'd0);
    exp_cpu_rd = exp_cpu_g && !cpu_wren;
    exp_cpu_q  = mem[cpu_addr[7:0]];
    rd_val     = mem[acc_addr[7:0]];
    obs_acc_gnt = acc_gnt; obs_stall = cpu_stall; obs_wren = wren;
    obs_addr = address_dmem; obs_data = data; obs_cpu_q = cpu_q;
    @(posedge clock);
    #1;
    mem_clr = 1'b0;
    if (reset) begin
      m_locked = 0; m_beats = 0; m_denied = 0; m_accq = '0; m_accqv = 0;
      m_stalls = '0; m_beatcnt = '0;
    end else begin
      if (exp_acc_g) begin
        m_beats  = m_locked ? m_beats + 1 : 1;
        m_locked = !acc_last && (m_beats < MAX_BURST);
        m_denied = 0;
      end else if (m_locked) begin
        m_locked = 0;
        m_denied = 0;
      end else begin
        m_denied = acc_req ? ((m_denied + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_denied + 1) : 0;
      end
      if (exp_acc_g && !acc_wren) begin m_accq = rd_val; m_accqv = 1; end
      else m_accqv = 0;
      if (exp_stall) m_stalls++;
      if (exp_acc_g) m_beatcnt++;
    end
    exp_accq = m_accq; exp_accqv = m_accqv;
    exp_stalls  = STATS ? m_stalls : 32'd0;
    exp_beatcnt = STATS ? m_beatcnt : 32'd0;
    obs_accq = acc_q; obs_accqv = acc_q_valid;
    obs_stalls = stat_cpu_stalls; obs_beatcnt = stat_acc_beats;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_wren = 0; acc_req = 0; acc_wren = 0; acc_last = 0;
  endtask

  task automatic do_reset();
    idle(); reset = 1; step(); reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; cpu_req = 1; cpu_wren = 1; acc_req = 1; acc_wren = 1;
    step();
    n_checks += 3;
    if (obs_acc_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %0b want 0", obs_acc_gnt); end
    if (obs_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %0b want 0", obs_wren); end
    if (obs_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %0b want 1", obs_stall); end
    idle(); reset = 0;
    step();
    n_checks += 4;
    if (obs_accqv !== 1'b0) begin n_fail++; $display("FAIL reset_qv: got %0b want 0", obs_accqv); end
    if (obs_accq !== 32'd0) begin n_fail++; $display("FAIL reset_accq: got %h want 0", obs_accq); end
    if (obs_stalls !== 32'd0) begin n_fail++; $display("FAIL reset_stat_stalls: got %0d want 0", obs_stalls); end
    if (obs_beatcnt !== 32'd0) begin n_fail++; $display("FAIL reset_stat_beats: got %0d want 0", obs_beatcnt); end
  endtask

  task automatic test_cpu_alone();
    idle(); cpu_req = 1; cpu_wren = 1; cpu_addr = 32'd5; cpu_data = 32'hDEADBEEF;
    step();
    n_checks += 4;
    if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_sw_stall: got %0b want 0", obs_stall); end
    if (obs_wren !== 1'b1) begin n_fail++; $display("FAIL cpu_sw_wren: got %0b want 1", obs_wren); end
    if (obs_addr !== 32'd5) begin n_fail++; $display("FAIL cpu_sw_addr: got %h want 5", obs_addr); end
    if (obs_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cpu_sw_data: got %h want deadbeef", obs_data); end
    cpu_wren = 0; cpu_data = 32'd0;
    step();
    n_checks += 3;
    if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_lw_stall: got %0b want 0", obs_stall); end
    if (obs_wren !== 1'b0) begin n_fail++; $display("FAIL cpu_lw_wren: got %0b want 0", obs_wren); end
    if (obs_cpu_q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cpu_lw_q: got %h want deadbeef", obs_cpu_q); end
    idle();
  endtask

  task automatic test_acc_burst();
    logic [31:0] vals [4];
    for (int i = 0; i < 4; i++) begin
      vals[i] = 32'hA000_0000 + 32'(i) * 32'd17;
      idle(); cpu_req = 1; cpu_wren = 1; cpu_addr = 32'(i); cpu_data = vals[i];
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      acc_req = 1; acc_wren = 0; acc_addr = 32'(i); acc_last = (i == 3);
      step();
      n_checks += 3;
      if (obs_acc_gnt !== 1'b1) begin n_fail++; $display("FAIL burst_gnt beat %0d: got %0b want 1", i, obs_acc_gnt); end
      if (obs_accqv !== 1'b1) begin n_fail++; $display("FAIL burst_qv beat %0d: got %0b want 1", i, obs_accqv); end
      if (obs_accq !== vals[i]) begin n_fail++; $display("FAIL burst_q beat %0d: got %h want %h", i, obs_accq, vals[i]); end
    end
    idle(); cpu_req = 1; cpu_addr = 32'd0;
    step();
    n_checks += 3;
    if (obs_accqv !== 1'b0) begin n_fail++; $display("FAIL burst_qv_after: got %0b want 0", obs_accqv); end
    if (obs_accq !== vals[3]) begin n_fail++; $display("FAIL burst_q_hold: got %h want %h", obs_accq, vals[3]); end
    if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL burst_open_after: cpu stall %0b want 0", obs_stall); end
    idle();
  endtask

  task automatic test_burst_limit();
    int b = 0;
    bit exp_acc;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cpu_req = 1; cpu_wren = 0; cpu_addr = 32'd9;
      acc_req = (b < 12); acc_wren = 0; acc_addr = 32'd100 + 32'(b); acc_last = (b == 11);
      step();
      if (obs_acc_gnt) b++;
      exp_acc = (c >= 4 && c <= 11) || (c >= 16 && c <= 19);
      n_checks += 2;
      if (obs_acc_gnt !== exp_acc) begin n_fail++; $display("FAIL limit_gnt cycle %0d: got %0b want %0b", c, obs_acc_gnt, exp_acc); end
      if (obs_stall !== exp_acc) begin n_fail++; $display("FAIL limit_stall cycle %0d: got %0b want %0b", c, obs_stall, exp_acc); end
      if (c == 12) begin
        n_checks++;
        if (obs_stalls !== (STATS ? 32'd8 : 32'd0))
          begin n_fail++; $display("FAIL limit_stat_stalls: got %0d want %0d", obs_stalls, STATS ? 8 : 0); end
      end
    end
    n_checks++;
    if (b != 12) begin n_fail++; $display("FAIL limit_total_beats: got %0d want 12", b); end
    idle();
  endtask

  task automatic test_starvation();
    bit exp_acc;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      cpu_req = 1; cpu_wren = 0; cpu_addr = 32'd3;
      acc_req = 1; acc_wren = 0; acc_addr = 32'd50; acc_last = 1;
      step();
      exp_acc = (c % 5 == 4);
      n_checks += 2;
      if (obs_acc_gnt !== exp_acc) begin n_fail++; $display("FAIL starve_gnt cycle %0d: got %0b want %0b", c, obs_acc_gnt, exp_acc); end
      if (obs_stall !== exp_acc) begin n_fail++; $display("FAIL starve_stall cycle %0d: got %0b want %0b", c, obs_stall, exp_acc); end
    end
    idle();
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      acc_req = 1; acc_wren = 1; acc_addr = 32'd200 + 32'(i); acc_data = 32'h1111 * 32'(i + 1); acc_last = 0;
      step();
    end
    reset = 1; acc_addr = 32'd202;
    step();
    n_checks += 2;
    if (obs_acc_gnt !== 1'b0) begin n_fail++; $display("FAIL midlock_reset_gnt: got %0b want 0", obs_acc_gnt); end
    if (obs_wren !== 1'b0) begin n_fail++; $display("FAIL midlock_reset_wren: got %0b want 0", obs_wren); end
    reset = 0; cpu_req = 1; cpu_wren = 0; cpu_addr = 32'd5;
    step();
    n_checks += 2;
    if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL midlock_cpu_after: stall %0b want 0", obs_stall); end
    if (obs_acc_gnt !== 1'b0) begin n_fail++; $display("FAIL midlock_acc_after: gnt %0b want 0", obs_acc_gnt); end
    idle();
  endtask

  task automatic test_abandoned();
    do_reset();
    acc_req = 1; acc_wren = 0; acc_addr = 32'd7; acc_last = 0;
    step();
    cpu_req = 1; cpu_wren = 0; cpu_addr = 32'd8; acc_addr = 32'd8;
    step();
    n_checks++;
    if (obs_stall !== 1'b1) begin n_fail++; $display("FAIL abandon_lock_stall: got %0b want 1", obs_stall); end
    acc_req = 0;
    step();
    n_checks += 3;
    if (obs_acc_gnt !== 1'b0) begin n_fail++; $display("FAIL abandon_gnt: got %0b want 0", obs_acc_gnt); end
    if (obs_stall !== 1'b1) begin n_fail++; $display("FAIL abandon_stall: got %0b want 1", obs_stall); end
    if (obs_wren !== 1'b0) begin n_fail++; $display("FAIL abandon_wren: got %0b want 0", obs_wren); end
    step();
    n_checks++;
    if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL abandon_reopen: stall %0b want 0", obs_stall); end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 199) == 0);
      cpu_req  = ($urandom_range(0, 2) != 0);
      cpu_wren = $urandom_range(0, 1);
      cpu_addr = $urandom; cpu_data = $urandom;
      acc_req  = ($urandom_range(0, 3) != 0);
      acc_wren = $urandom_range(0, 1);
      acc_addr = $urandom; acc_data = $urandom;
      acc_last = ($urandom_range(0, 5) == 0);
      step();
      n_checks += 8;
      if (obs_acc_gnt !== exp_acc_g) begin n_fail++; $display("FAIL rand_gnt cycle %0d: got %0b want %0b", c, obs_acc_gnt, exp_acc_g); end
      if (obs_stall !== exp_stall) begin n_fail++; $display("FAIL rand_stall cycle %0d: got %0b want %0b", c, obs_stall, exp_stall); end
      if (obs_wren !== exp_wren) begin n_fail++; $display("FAIL rand_wren cycle %0d: got %0b want %0b", c, obs_wren, exp_wren); end
      if (obs_addr !== exp_addr) begin n_fail++; $display("FAIL rand_addr cycle %0d: got %h want %h", c, obs_addr, exp_addr); end
      if (obs_data !== exp_data) begin n_fail++; $display("FAIL rand_data cycle %0d: got %h want %h", c, obs_data, exp_data); end
      if (obs_accqv !== exp_accqv) begin n_fail++; $display("FAIL rand_qv cycle %0d: got %0b want %0b", c, obs_accqv, exp_accqv); end
      if (obs_stalls !== exp_stalls) begin n_fail++; $display("FAIL rand_stat_stalls cycle %0d: got %0d want %0d", c, obs_stalls, exp_stalls); end
      if (obs_beatcnt !== exp_beatcnt) begin n_fail++; $display("FAIL rand_stat_beats cycle %0d: got %0d want %0d", c, obs_beatcnt, exp_beatcnt); end
      if (exp_accqv) begin
        n_checks++;
        if (obs_accq !== exp_accq) begin n_fail++; $display("FAIL rand_accq cycle %0d: got %h want %h", c, obs_accq, exp_accq); end
      end
      if (exp_cpu_rd) begin
        n_checks++;
        if (obs_cpu_q !== exp_cpu_q) begin n_fail++; $display("FAIL rand_cpu_q cycle %0d: got %h want %h", c, obs_cpu_q, exp_cpu_q); end
      end
    end
    reset = 0;
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_alone();
    test_acc_burst();
    test_burst_limit();
    test_starvation();
    test_reset_mid_lock();
    test_abandoned();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
